alu_muldiv: RTL and testbench

Iterative multiply/divide unit with architectural HI/LO registers for the MIPS32 datapath. It sits beside the combinational ALU in EX, parametrised in word width. It executes MULT/MULTU/DIV/DIVU over multiple cycles under a Start/Busy/Done handshake, and services MTHI/MTLO in a single cycle. The pipeline stalls on Busy and reads Hi/Lo directly for MFHI/MFLO.

---
 rtl/alu_muldiv_if.sv | 17 +
 rtl/alu_muldiv.sv | 158 +++++++++++++++
 tb/tb_alu_muldiv.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/alu_muldiv_if.sv
// Start/Busy/Done request bus between the EX stage and the multiply/divide unit.
interface alu_muldiv_if #(
  parameter int W        = 32,
  parameter int CTRL_LEN = 3
);
  logic                Start;
  logic [CTRL_LEN-1:0] MDCtrl;
  logic [W-1:0]        Op1;
  logic [W-1:0]        Op2;
  logic                Busy;
  logic                Done;
  logic [W-1:0]        Hi;
  logic [W-1:0]        Lo;

  modport master (output Start, MDCtrl, Op1, Op2, input Busy, Done, Hi, Lo);
  modport slave  (input Start, MDCtrl, Op1, Op2, output Busy, Done, Hi, Lo);
endinterface

// File: rtl/alu_muldiv.sv
// Iterative MULT/MULTU/DIV/DIVU with HI/LO; W+1 edges per op, MTHI/MTLO in one edge, Start ignored while Busy.
// MULDIV_FAST_MUL_EN: single-cycle array multiply for MULT/MULTU (Hi/Lo written one edge after accept).
module alu_muldiv #(
  parameter int W        = 32,
  parameter int CTRL_LEN = 3
) (
  input  logic         clk,
  input  logic         rst,
  alu_muldiv_if.slave  md
);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] FIX  = 2'd2;
  localparam int CW = $clog2(W);

  logic [1:0]     state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [2*W-1:0] acc_q, acc_d;
  logic [W-1:0]   mag_q, mag_d;
  logic           is_div_q, is_div_d;
  logic           neg_q, neg_d;
  logic           rneg_q, rneg_d;
  logic           div0_q, div0_d;
  logic [W-1:0]   hi_q, hi_d, lo_q, lo_d;
  logic           done_q, done_d;

  logic           sgn, sa, sb;
  logic [W-1:0]   absa, absb;
  logic [W:0]     rem, diff, sum;
  logic [W-1:0]   quo, rmd;

  assign sgn  = ~md.MDCtrl[0];
  assign sa   = sgn & md.Op1[W-1];
  assign sb   = sgn & md.Op2[W-1];
  assign absa = sa ? -md.Op1 : md.Op1;
  assign absb = sb ? -md.Op2 : md.Op2;

  // Restoring divide step: shift the next dividend bit into the partial remainder.
  assign rem  = {acc_q[2*W-1:W], acc_q[W-1]};
  assign diff = rem - {1'b0, mag_q};
  assign sum  = {1'b0, acc_q[2*W-1:W]} + ({(W+1){acc_q[0]}} & {1'b0, mag_q});
  assign quo  = acc_q[W-1:0];
  assign rmd  = acc_q[2*W-1:W];

`ifdef MULDIV_FAST_MUL_EN
  // Fast path keeps raw operands in acc_q and the signedness in neg_q.
  logic [2*W-1:0] fa, fb, fprod;
  assign fa    = neg_q ? {{W{acc_q[2*W-1]}}, acc_q[2*W-1:W]} : {{W{1'b0}}, acc_q[2*W-1:W]};
  assign fb    = neg_q ? {{W{acc_q[W-1]}}, acc_q[W-1:0]} : {{W{1'b0}}, acc_q[W-1:0]};
  assign fprod = fa * fb;
`else
  logic [2*W-1:0] mprod;
  assign mprod = neg_q ? -acc_q : acc_q;
`endif

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    mag_d    = mag_q;
    is_div_d = is_div_q;
    neg_d    = neg_q;
    rneg_d   = rneg_q;
    div0_d   = div0_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    done_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (md.Start) begin
          case (md.MDCtrl)
            CTRL_LEN'(0), CTRL_LEN'(1), CTRL_LEN'(2), CTRL_LEN'(3): begin
              is_div_d = md.MDCtrl[1];
              neg_d    = sa ^ sb;
              rneg_d   = sa;
              div0_d   = (md.Op2 == '0);
              cnt_d    = '0;
              state_d  = RUN;
              if (md.MDCtrl[1]) begin
                acc_d = {{W{1'b0}}, absa};
                mag_d = absb;
              end else begin
                acc_d = {{W{1'b0}}, absb};
                mag_d = absa;
`ifdef MULDIV_FAST_MUL_EN
                acc_d   = {md.Op1, md.Op2};
                neg_d   = sgn;
                state_d = FIX;
`endif
              end
            end
            CTRL_LEN'(4): hi_d = md.Op1;
            CTRL_LEN'(5): lo_d = md.Op1;
            default: ;
          endcase
        end
      end
      RUN: begin
        if (is_div_q) begin
          if (!diff[W]) acc_d = {diff[W-1:0], acc_q[W-2:0], 1'b1};
          else          acc_d = {rem[W-1:0], acc_q[W-2:0], 1'b0};
        end else begin
          acc_d = {sum, acc_q[W-1:1]};
        end
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(W-1)) state_d = FIX;
      end
      FIX: begin
        if (is_div_q) begin
          lo_d = div0_q ? '1 : (neg_q ? -quo : quo);
          hi_d = rneg_q ? -rmd : rmd;
        end else begin
`ifdef MULDIV_FAST_MUL_EN
          {hi_d, lo_d} = fprod;
`else
          {hi_d, lo_d} = mprod;
`endif
        end
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      mag_q    <= '0;
      is_div_q <= 1'b0;
      neg_q    <= 1'b0;
      rneg_q   <= 1'b0;
      div0_q   <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      mag_q    <= mag_d;
      is_div_q <= is_div_d;
      neg_q    <= neg_d;
      rneg_q   <= rneg_d;
      div0_q   <= div0_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      done_q   <= done_d;
    end
  end

  assign md.Busy = (state_q != IDLE);
  assign md.Done = done_q;
  assign md.Hi   = hi_q;
  assign md.Lo   = lo_q;
endmodule

// File: tb/tb_alu_muldiv.sv
// Directed bench for alu_muldiv (W=32): vector table plus reset/ignore/MT sequences.
module tb_alu_muldiv;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  alu_muldiv_if #(.W(32), .CTRL_LEN(3)) bus ();
  alu_muldiv #(.W(32), .CTRL_LEN(3)) dut (.clk(clk), .rst(rst), .md(bus));

`ifdef MULDIV_FAST_MUL_EN
  localparam int MUL_LAT = 1;
`else
  localparam int MUL_LAT = 33;
`endif
  localparam int DIV_LAT = 33;

  typedef struct {
    logic [2:0]  ctrl;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
  } vec_t;

  vec_t vecs[12];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Accept at E0, then watch 40 cycles: Busy cycles, Done pulses, first Done cycle.
  task automatic run_op(input logic [2:0] c, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] hi, output logic [31:0] lo,
                        output int busy_n, output int done_n, output int lat);
    busy_n = 0; done_n = 0; lat = -1;
    @(negedge clk);
    bus.Start = 1'b1; bus.MDCtrl = c; bus.Op1 = a; bus.Op2 = b;
    @(posedge clk);
    #1 bus.Start = 1'b0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (bus.Busy) busy_n++;
      if (bus.Done) begin
        done_n++;
        if (lat < 0) lat = i - 1;
      end
    end
    hi = bus.Hi; lo = bus.Lo;
  endtask

  initial begin
    logic [31:0] hi, lo;
    int busy_n, done_n, lat, exp_lat;
    string nm;

    vecs[0]  = '{3'd0, 32'hFFFFFFFE, 32'h00000003, 32'hFFFFFFFF, 32'hFFFFFFFA};
    vecs[1]  = '{3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};
    vecs[2]  = '{3'd0, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000};
    vecs[3]  = '{3'd2, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD};
    vecs[4]  = '{3'd3, 32'hFFFFFFF9, 32'h00000002, 32'h00000001, 32'h7FFFFFFC};
    vecs[5]  = '{3'd2, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000};
    vecs[6]  = '{3'd3, 32'h00000005, 32'h00000000, 32'h00000005, 32'hFFFFFFFF};
    vecs[7]  = '{3'd2, 32'hFFFFFFFB, 32'h00000000, 32'hFFFFFFFB, 32'hFFFFFFFF};
    vecs[8]  = '{3'd0, 32'h00000007, 32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFEB};
    vecs[9]  = '{3'd2, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD};
    vecs[10] = '{3'd1, 32'h00000003, 32'h00000004, 32'h00000000, 32'h0000000C};
    vecs[11] = '{3'd3, 32'h00000064, 32'h00000007, 32'h00000002, 32'h0000000E};

    bus.Start = 1'b0; bus.MDCtrl = '0; bus.Op1 = '0; bus.Op2 = '0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_hi", 64'(bus.Hi), 64'h0);
    check("rst_lo", 64'(bus.Lo), 64'h0);
    check("rst_busy", 64'(bus.Busy), 64'h0);
    check("rst_done", 64'(bus.Done), 64'h0);
    rst = 1'b0;

    for (int k = 0; k < 12; k++) begin
      run_op(vecs[k].ctrl, vecs[k].a, vecs[k].b, hi, lo, busy_n, done_n, lat);
      exp_lat = vecs[k].ctrl[1] ? DIV_LAT : MUL_LAT;
      nm = $sformatf("vec%0d", k);
      check({nm, "_hi"}, 64'(hi), 64'(vecs[k].hi));
      check({nm, "_lo"}, 64'(lo), 64'(vecs[k].lo));
      check({nm, "_busy_cycles"}, 64'(busy_n), 64'(exp_lat));
      check({nm, "_done_pulses"}, 64'(done_n), 64'h1);
      check({nm, "_latency"}, 64'(lat), 64'(exp_lat));
    end

    // DIVU 100/7 with an MTHI request and operand changes while Busy.
    @(negedge clk);
    bus.Start = 1'b1; bus.MDCtrl = 3'd3; bus.Op1 = 32'd100; bus.Op2 = 32'd7;
    @(posedge clk);
    #1 bus.Start = 1'b0;
    repeat (4) @(negedge clk);
    bus.Start = 1'b1; bus.MDCtrl = 3'd4; bus.Op1 = 32'h1234; bus.Op2 = 32'd9;
    check("busy_hi_hold", 64'(bus.Hi), 64'h2);
    @(negedge clk);
    bus.Start = 1'b0; bus.Op1 = 32'hDEAD;
    done_n = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.Done) done_n++;
    end
    check("ign_lo", 64'(bus.Lo), 64'd14);
    check("ign_hi", 64'(bus.Hi), 64'd2);
    check("ign_done_pulses", 64'(done_n), 64'h1);

    // MTHI then MTLO on consecutive edges.
    busy_n = 0; done_n = 0;
    @(negedge clk);
    bus.Start = 1'b1; bus.MDCtrl = 3'd4; bus.Op1 = 32'h1234;
    @(negedge clk);
    bus.MDCtrl = 3'd5; bus.Op1 = 32'hABCD;
    busy_n += int'(bus.Busy); done_n += int'(bus.Done);
    @(negedge clk);
    bus.Start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      busy_n += int'(bus.Busy); done_n += int'(bus.Done);
      @(negedge clk);
    end
    check("mt_hi", 64'(bus.Hi), 64'h1234);
    check("mt_lo", 64'(bus.Lo), 64'hABCD);
    check("mt_busy", 64'(busy_n), 64'h0);
    check("mt_done", 64'(done_n), 64'h0);

    // Reserved opcode: accepted, nothing changes.
    run_op(3'd7, 32'h5555, 32'h1, hi, lo, busy_n, done_n, lat);
    check("rsv_hi", 64'(hi), 64'h1234);
    check("rsv_lo", 64'(lo), 64'hABCD);
    check("rsv_busy", 64'(busy_n), 64'h0);

    // MULT 3x4 interrupted by reset.
    @(negedge clk);
    bus.Start = 1'b1; bus.MDCtrl = 3'd0; bus.Op1 = 32'd3; bus.Op2 = 32'd4;
    @(posedge clk);
    #1 bus.Start = 1'b0;
    repeat (9) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst_busy", 64'(bus.Busy), 64'h0);
    check("midrst_hi", 64'(bus.Hi), 64'h0);
    check("midrst_lo", 64'(bus.Lo), 64'h0);
    done_n = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.Done) done_n++;
    end
    check("midrst_no_done", 64'(done_n), 64'h0);

    run_op(3'd1, 32'd3, 32'd4, hi, lo, busy_n, done_n, lat);
    check("post_rst_hi", 64'(hi), 64'h0);
    check("post_rst_lo", 64'(lo), 64'd12);
    check("post_rst_done", 64'(done_n), 64'h1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
